brick_memory: RTL and testbench



---
 rtl/brick_pkg.sv | 37 +++
 rtl/brick_refill_ctrl.sv | 50 +++++
 rtl/brick_memory.sv | 101 ++++++++++
 tb/tb_brick_memory.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/brick_pkg.sv
// Shared brick-field constants, refill FSM state type and the pixel-to-brick index mapping.
package brick_pkg;

  localparam int         BRICKX      = 32;
  localparam int         BRICKY      = 16;
  localparam int         COLS        = 20;
  localparam int         ROWS        = 8;
  localparam int         HEALTH_W    = 2;
  localparam logic [1:0] INIT_HEALTH = 2'd3;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } refill_state_t;

  typedef struct packed {
    logic       in_range;
    logic [7:0] idx;
  } brick_loc_t;

  // Range check happens before the row*cols product is used, so idx never wraps.
  function automatic brick_loc_t pix_to_idx(input logic [9:0] x, input logic [9:0] y,
                                            input int lx, input int ly,
                                            input int cols, input int rows);
    brick_loc_t loc;
    logic [9:0] col;
    logic [9:0] row;
    int         lin;
    col = x >> lx;
    row = y >> ly;
    loc.in_range = (int'(col) < cols) && (int'(row) < rows);
    lin = int'(row) * cols + int'(col);
    loc.idx = loc.in_range ? 8'(lin) : 8'd0;
    return loc;
  endfunction

endpackage

// File: rtl/brick_refill_ctrl.sv
// Level refill sequencer: walks a write pointer across every brick, one per cycle.
module brick_refill_ctrl #(
  parameter int N_BRICKS = 160
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  output logic       busy,
  output logic       wr_en,
  output logic [7:0] wr_idx,
  output logic       done
);
  import brick_pkg::*;

  localparam logic [7:0] LAST = 8'(N_BRICKS - 1);

  refill_state_t state;
  logic [7:0]    ptr;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
      ptr   <= 8'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_FILL;
            ptr   <= 8'd0;
          end
        end
        S_FILL: begin
          if (ptr == LAST) begin
            state <= S_IDLE;
            ptr   <= 8'd0;
          end else begin
            ptr <= ptr + 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy   = (state == S_FILL);
  assign wr_en  = busy;
  assign wr_idx = ptr;
  assign done   = busy && (ptr == LAST);

endmodule

// File: rtl/brick_memory.sv
// Brick-field state: per-brick health, query port for the ball FSM, dual hit ports, refill.
module brick_memory #(
  parameter int         BRICKX      = brick_pkg::BRICKX,
  parameter int         BRICKY      = brick_pkg::BRICKY,
  parameter int         COLS        = brick_pkg::COLS,
  parameter int         ROWS        = brick_pkg::ROWS,
  parameter logic [1:0] INIT_HEALTH = brick_pkg::INIT_HEALTH
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [9:0] memx,
  input  logic [9:0] memy,
  output logic [9:0] brickx,
  output logic [9:0] bricky,
  output logic [1:0] health,
  input  logic       hit_1,
  input  logic [9:0] col_x1,
  input  logic [9:0] col_y1,
  input  logic       hit_2,
  input  logic [9:0] col_x2,
  input  logic [9:0] col_y2,
  input  logic       refill_go,
  output logic       busy,
  output logic [7:0] bricks_left,
  output logic       all_clear
);
  import brick_pkg::*;

  localparam int         LX    = $clog2(BRICKX);
  localparam int         LY    = $clog2(BRICKY);
  localparam int         NB    = COLS * ROWS;
  localparam logic [9:0] XMASK = 10'(~(BRICKX - 1));
  localparam logic [9:0] YMASK = 10'(~(BRICKY - 1));

  logic [HEALTH_W-1:0] mem [NB];

  brick_loc_t          q_loc, h1_loc, h2_loc;
  logic [HEALTH_W-1:0] cur1, cur2;
  logic                dec1, dec2, same_idx, zero1, zero2;
  logic                wr_en, done;
  logic [7:0]          wr_idx;

  brick_refill_ctrl #(.N_BRICKS(NB)) u_refill (
    .clk    (clk),
    .resetn (resetn),
    .start  (refill_go),
    .busy   (busy),
    .wr_en  (wr_en),
    .wr_idx (wr_idx),
    .done   (done)
  );

  assign q_loc  = pix_to_idx(memx, memy, LX, LY, COLS, ROWS);
  assign h1_loc = pix_to_idx(col_x1, col_y1, LX, LY, COLS, ROWS);
  assign h2_loc = pix_to_idx(col_x2, col_y2, LX, LY, COLS, ROWS);

  assign cur1     = mem[h1_loc.idx];
  assign cur2     = mem[h2_loc.idx];
  assign dec1     = hit_1 && h1_loc.in_range && (cur1 != '0) && !busy;
  assign dec2     = hit_2 && h2_loc.in_range && (cur2 != '0) && !busy;
  assign same_idx = (h1_loc.idx == h2_loc.idx);
  // Both ports on one brick collapse to a single decrement, so count that 1->0 only once.
  assign zero1    = dec1 && (cur1 == 2'd1);
  assign zero2    = dec2 && (cur2 == 2'd1) && !(dec1 && same_idx);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NB; i++) mem[i] <= INIT_HEALTH;
    end else if (wr_en) begin
      mem[wr_idx] <= INIT_HEALTH;
    end else begin
      if (dec1) mem[h1_loc.idx] <= cur1 - 2'd1;
      if (dec2) mem[h2_loc.idx] <= cur2 - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      brickx <= 10'd0;
      bricky <= 10'd0;
      health <= 2'd0;
    end else begin
      brickx <= q_loc.in_range ? (memx & XMASK) : 10'd0;
      bricky <= q_loc.in_range ? (memy & YMASK) : 10'd0;
      health <= (q_loc.in_range && !busy) ? mem[q_loc.idx] : 2'd0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bricks_left <= 8'(NB);
    end else if (done) begin
      bricks_left <= 8'(NB);
    end else begin
      bricks_left <= bricks_left - {7'd0, zero1} - {7'd0, zero2};
    end
  end

  assign all_clear = (bricks_left == 8'd0) && !busy;

endmodule

// File: tb/tb_brick_memory.sv
// Scoreboard bench for brick_memory: queries push expected results, a monitor pops and compares.
module tb_brick_memory;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic [9:0] memx = '0, memy = '0;
  logic [9:0] brickx, bricky;
  logic [1:0] health;
  logic       hit_1 = 1'b0, hit_2 = 1'b0;
  logic [9:0] col_x1 = '0, col_y1 = '0, col_x2 = '0, col_y2 = '0;
  logic       refill_go = 1'b0;
  logic       busy;
  logic [7:0] bricks_left;
  logic       all_clear;

  typedef struct {
    logic [9:0] bx;
    logic [9:0] by;
    logic [1:0] h;
  } exp_t;

  exp_t expq[$];
  logic q_issued = 1'b0;
  logic pend = 1'b0;
  int   checks = 0;
  int   errors = 0;

  brick_memory dut (
    .clk         (clk),
    .resetn      (resetn),
    .memx        (memx),
    .memy        (memy),
    .brickx      (brickx),
    .bricky      (bricky),
    .health      (health),
    .hit_1       (hit_1),
    .col_x1      (col_x1),
    .col_y1      (col_y1),
    .hit_2       (hit_2),
    .col_x2      (col_x2),
    .col_y2      (col_y2),
    .refill_go   (refill_go),
    .busy        (busy),
    .bricks_left (bricks_left),
    .all_clear   (all_clear)
  );

  always #5 clk = ~clk;

  always @(posedge clk) pend <= q_issued && resetn;

  // Monitor: one registered query result is due half a cycle after each issuing edge.
  always @(negedge clk) begin
    if (pend) begin
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL monitor_underflow: got result bx=%0d by=%0d h=%0d, no expectation queued",
                 brickx, bricky, health);
      end else begin
        exp_t e;
        e = expq.pop_front();
        if (brickx !== e.bx || bricky !== e.by || health !== e.h) begin
          errors++;
          $display("FAIL query_result: got bx=%0d by=%0d h=%0d, want bx=%0d by=%0d h=%0d",
                   brickx, bricky, health, e.bx, e.by, e.h);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic set_query(input logic [9:0] x, input logic [9:0] y,
                           input logic [9:0] ebx, input logic [9:0] eby, input logic [1:0] eh);
    exp_t e;
    memx = x;
    memy = y;
    q_issued = 1'b1;
    e.bx = ebx;
    e.by = eby;
    e.h  = eh;
    expq.push_back(e);
  endtask

  task automatic set_hit1(input logic [9:0] x, input logic [9:0] y);
    hit_1 = 1'b1; col_x1 = x; col_y1 = y;
  endtask

  task automatic set_hit2(input logic [9:0] x, input logic [9:0] y);
    hit_2 = 1'b1; col_x2 = x; col_y2 = y;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    hit_1 = 1'b0;
    hit_2 = 1'b0;
    q_issued = 1'b0;
    refill_go = 1'b0;
  endtask

  initial begin
    #3 resetn = 1'b0;
    #2;
    check("reset_brickx", brickx, 0);
    check("reset_bricky", bricky, 0);
    check("reset_health", health, 0);
    check("reset_busy", busy, 0);
    check("reset_left", bricks_left, 160);
    check("reset_all_clear", all_clear, 0);
    @(posedge clk); @(posedge clk); #1;
    resetn = 1'b1;

    // 1: basic query
    set_query(45, 20, 32, 16, 3); step();
    check("left_after_reset", bricks_left, 160);

    // 2: out-of-range queries
    set_query(650, 20, 0, 0, 0); step();
    set_query(10, 130, 0, 0, 0); step();
    set_query(639, 127, 608, 112, 3); step();

    // 3: single hits on brick (32,16), saturation at 0
    set_hit1(32, 16); step();
    set_query(32, 16, 32, 16, 2); step();
    set_hit1(32, 16); step();
    set_query(32, 16, 32, 16, 1); step();
    set_hit1(32, 16); step();
    set_query(32, 16, 32, 16, 0); step();
    check("left_after_third_hit", bricks_left, 159);
    set_hit2(32, 16); step();
    set_query(32, 16, 32, 16, 0); step();
    check("left_after_fourth_hit", bricks_left, 159);

    // read-before-write on the same brick
    set_hit1(64, 16); set_query(64, 16, 64, 16, 3); step();
    set_query(64, 16, 64, 16, 2); step();

    // hits outside the grid change nothing
    set_hit1(650, 0); set_hit2(0, 200); step();
    set_query(0, 0, 0, 0, 3); step();

    // 4: dual hits, same brick then different bricks
    set_hit1(0, 0); set_hit2(5, 7); step();
    set_query(0, 0, 0, 0, 2); step();
    set_hit1(0, 0); step();
    set_hit2(32, 0); step();
    set_hit2(32, 0); step();
    set_query(32, 0, 32, 0, 1); step();
    check("left_before_dual", bricks_left, 159);
    set_hit1(0, 0); set_hit2(32, 0); step();
    check("left_after_dual", bricks_left, 157);
    set_query(0, 0, 0, 0, 0); step();
    set_query(32, 0, 32, 0, 0); step();

    // 5: drain, then refill
    for (int i = 0; i < 160; i++) begin
      for (int k = 0; k < 3; k++) begin
        set_hit1(10'((i % 20) * 32), 10'((i / 20) * 16));
        step();
      end
    end
    check("left_drained", bricks_left, 0);
    check("all_clear_drained", all_clear, 1);
    refill_go = 1'b1; step();
    check("busy_rise", busy, 1);
    check("all_clear_busy", all_clear, 0);
    for (int c = 1; c < 160; c++) begin
      set_query(45, 20, 32, 16, 0);
      if (c == 5) refill_go = 1'b1;
      if (c == 7) set_hit1(0, 0);
      step();
      if (busy !== 1'b1) check("busy_window", busy, 1);
    end
    set_query(45, 20, 32, 16, 0); step();
    check("busy_fall", busy, 0);
    check("left_refilled", bricks_left, 160);
    check("all_clear_refilled", all_clear, 0);
    set_query(45, 20, 32, 16, 3); step();
    set_query(0, 0, 0, 0, 3); step();

    // 6: reset mid-refill
    refill_go = 1'b1; step();
    for (int c = 1; c <= 50; c++) begin
      if (c < 45) set_query(45, 20, 32, 16, 0);
      step();
    end
    check("busy_mid_refill", busy, 1);
    check("brickx_before_reset", brickx, 32);
    resetn = 1'b0;
    #2;
    check("mid_reset_brickx", brickx, 0);
    check("mid_reset_bricky", bricky, 0);
    check("mid_reset_busy", busy, 0);
    check("mid_reset_left", bricks_left, 160);
    check("mid_reset_all_clear", all_clear, 0);
    @(posedge clk); @(posedge clk); #1;
    resetn = 1'b1;
    for (int i = 0; i < 160; i++) begin
      set_query(10'((i % 20) * 32 + 3), 10'((i / 20) * 16 + 9),
                10'((i % 20) * 32), 10'((i / 20) * 16), 3);
      step();
    end
    check("busy_after_reset", busy, 0);
    check("left_after_reset_refill", bricks_left, 160);

    for (int w = 0; w < 10 && expq.size() != 0; w++) step();
    step();
    check("queue_empty", expq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, want completion before 200000");
    $fatal(1);
  end

endmodule
